flag_stream_checker: RTL and testbench

- Downstream consumer of the byte-transform stage: takes the stream of transformed bytes and compares each one against an expected-ciphertext table.
- Produces a pass/fail verdict, a mismatch count and the index of the first mismatching byte.
- Replaces the current testbench-side $display inspection with synthesizable on-chip checking.
- The expected table is loaded through a simple write port before each check run.

---
 rtl/flag_pkg.sv | 20 ++
 rtl/flag_stream_checker_if.sv | 13 +
 rtl/flag_exp_ram.sv | 26 ++
 rtl/flag_stream_checker.sv | 105 ++++++++++
 tb/tb_flag_stream_checker.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/flag_pkg.sv
// Shared types and defaults for the flag stream checker.
package flag_pkg;

  localparam int DEPTH_DEF = 64;
  localparam int DW_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/flag_stream_checker_if.sv
// Byte stream handshake from the transform stage into the checker.
interface flag_stream_checker_if
  import flag_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/flag_exp_ram.sv
// Expected-byte table: one synchronous write port, one combinational read port.
module flag_exp_ram
  import flag_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // Contents are deliberately not reset; the table is loaded before every use.
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/flag_stream_checker.sv
// Compares an incoming byte stream against the expected table and reports a verdict.
// state | meaning
// IDLE  | table writable, waiting for start
// CHECK | accepting and comparing beats until len have been taken
// DONE  | verdict held until start, abort or rst
module flag_stream_checker
  import flag_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exp_we,
  input  logic [AW-1:0]         exp_addr,
  input  logic [DW-1:0]         exp_data,
  input  logic                  start,
  input  logic [AW:0]           len,
  input  logic                  abort,
  flag_stream_checker_if.slave  s,
  output logic                  done,
  output logic                  pass,
  output logic [AW:0]           err_count,
  output logic [AW-1:0]         first_bad,
  output logic [AW:0]           idx
);

  state_t        state, state_n;
  logic [AW:0]   len_q, len_n;
  logic [AW:0]   err_n, idx_n;
  logic [AW-1:0] first_bad_n;
  logic [DW-1:0] exp_byte;
  logic [AW:0]   idx_inc;
  logic          accept;

  flag_exp_ram #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (exp_we && (state == IDLE)),
    .waddr (exp_addr),
    .wdata (exp_data),
    .raddr (idx[AW-1:0]),
    .rdata (exp_byte)
  );

  assign s.in_ready = (state == CHECK);
  assign accept     = s.in_valid && s.in_ready;
  assign idx_inc    = idx + (AW+1)'(1);
  assign done       = (state == DONE);
  assign pass       = done && (err_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      err_count <= '0;
      first_bad <= '0;
      idx       <= '0;
    end else begin
      state     <= state_n;
      len_q     <= len_n;
      err_count <= err_n;
      first_bad <= first_bad_n;
      idx       <= idx_n;
    end
  end

  always_comb begin
    state_n     = state;
    len_n       = len_q;
    err_n       = err_count;
    first_bad_n = first_bad;
    idx_n       = idx;
    if (abort) begin
      state_n     = IDLE;
      err_n       = '0;
      first_bad_n = '0;
      idx_n       = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            len_n       = len;
            err_n       = '0;
            first_bad_n = '0;
            idx_n       = '0;
            state_n     = (len == '0) ? DONE : CHECK;
          end
        end
        CHECK: begin
          if (accept) begin
            if (s.in_data != exp_byte) begin
              err_n = err_count + (AW+1)'(1);
              if (err_count == '0) first_bad_n = idx[AW-1:0];
            end
            idx_n = idx_inc;
            if (idx_inc == len_q) state_n = DONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_stream_checker.sv
// Directed and randomized checks of flag_stream_checker against a table-walk model.
module tb_flag_stream_checker;
  import flag_pkg::*;

  localparam int DEPTH = 64;
  localparam int DW    = 8;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          abort = 1'b0;
  logic          done, pass;
  logic [AW:0]   err_count, idx;
  logic [AW-1:0] first_bad;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] tab_m [DEPTH];
  logic [DW-1:0] str   [DEPTH];

  flag_stream_checker_if #(.DW(DW)) sif ();

  flag_stream_checker #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .exp_we    (exp_we),
    .exp_addr  (exp_addr),
    .exp_data  (exp_data),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .s         (sif),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .first_bad (first_bad),
    .idx       (idx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(sif.in_ready), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
    chk({tag, "_first_bad"}, 32'(first_bad), 0);
    chk({tag, "_idx"}, 32'(idx), 0);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    exp_we = 1'b1;
    exp_addr = AW'(a);
    exp_data = d;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic go(input int l);
    start = 1'b1;
    len = (AW+1)'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] b);
    sif.in_valid = 1'b1;
    sif.in_data = b;
    for (int t = 0; t < 64 && !sif.in_ready; t++) tick();
    chk("in_ready_at_beat", 32'(sif.in_ready), 1);
    tick();
  endtask

  task automatic verdict(input string tag, input int l, input int e, input int fb);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_in_ready"}, 32'(sif.in_ready), 0);
    chk({tag, "_idx"}, 32'(idx), 32'(l));
    chk({tag, "_err_count"}, 32'(err_count), 32'(e));
    chk({tag, "_first_bad"}, 32'(first_bad), 32'(fb));
    chk({tag, "_pass"}, 32'(pass), (e == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [DW-1:0] good [4];
    logic [DW-1:0] bad  [4];
    int pat [7];
    int cnt, l, e, fb;

    good = '{8'hA1, 8'h5C, 8'h07, 8'hFF};
    bad  = '{8'hA1, 8'h5C, 8'h06, 8'hFE};
    pat  = '{1, 0, 0, 1, 1, 0, 1};
    sif.in_valid = 1'b0;
    sif.in_data = '0;

    // reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_zero("reset");
    tick();
    chk_zero("reset_hold");

    // load table: random background, fixed first four entries
    for (int i = 0; i < DEPTH; i++) tab_m[i] = DW'($urandom);
    for (int i = 0; i < 4; i++) tab_m[i] = good[i];
    for (int i = 0; i < DEPTH; i++) wr(i, tab_m[i]);

    // exact match, back-to-back
    go(4);
    chk("match_ready_after_start", 32'(sif.in_ready), 1);
    chk("match_done_early", 32'(done), 0);
    for (int i = 0; i < 4; i++) beat(good[i]);
    sif.in_valid = 1'b0;
    verdict("match", 4, 0, 0);
    tick();
    chk("match_done_held", 32'(done), 1);

    // two mismatches, restart straight from DONE
    go(4);
    for (int i = 0; i < 4; i++) beat(bad[i]);
    sif.in_valid = 1'b0;
    verdict("mismatch", 4, 2, 2);

    // stalls, with a table write attempted during CHECK
    go(4);
    cnt = 0;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin
        exp_we = 1'b1;
        exp_addr = '0;
        exp_data = 8'h00;
      end
      if (pat[k] == 1) begin
        beat(good[cnt]);
        cnt++;
      end else begin
        sif.in_valid = 1'b0;
        tick();
      end
      exp_we = 1'b0;
      if (k < 6) chk("stall_idx", 32'(idx), 32'(cnt));
    end
    sif.in_valid = 1'b0;
    verdict("stall", 4, 0, 0);

    // zero-length run
    go(0);
    verdict("len0", 0, 0, 0);

    // abort mid-run with a beat offered at the same time
    go(4);
    beat(good[0]);
    beat(good[1]);
    abort = 1'b1;
    sif.in_valid = 1'b1;
    sif.in_data = good[2];
    tick();
    abort = 1'b0;
    sif.in_valid = 1'b0;
    chk_zero("abort");

    // table retained, including entry 0 after the ignored write
    go(4);
    for (int i = 0; i < 4; i++) beat(good[i]);
    sif.in_valid = 1'b0;
    verdict("after_abort", 4, 0, 0);

    // reset mid-run
    go(4);
    beat(good[0]);
    beat(8'h00);
    chk("midrst_err_before", 32'(err_count), 1);
    rst = 1'b1;
    sif.in_valid = 1'b1;
    tick();
    rst = 1'b0;
    sif.in_valid = 1'b0;
    chk_zero("midrst");

    // randomized runs against the table-walk model
    for (int r = 0; r < 6; r++) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tab_m[i] = DW'($urandom);
        wr(i, tab_m[i]);
      end
      l = (r == 0) ? DEPTH : (r == 1) ? 1 : int'($urandom_range(2, DEPTH - 1));
      for (int i = 0; i < l; i++)
        str[i] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : tab_m[i];
      e = 0;
      fb = 0;
      for (int i = 0; i < l; i++) begin
        if (str[i] != tab_m[i]) begin
          if (e == 0) fb = i;
          e++;
        end
      end
      go(l);
      for (int i = 0; i < l; i++) begin
        if (i == l / 2) begin
          start = 1'b1;
          len = (AW+1)'(1);
          sif.in_valid = 1'b0;
          tick();
          start = 1'b0;
          chk("rand_start_ignored_idx", 32'(idx), 32'(i));
        end
        for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
          sif.in_valid = 1'b0;
          sif.in_data = DW'($urandom);
          tick();
          chk("rand_gap_idx", 32'(idx), 32'(i));
        end
        beat(str[i]);
      end
      sif.in_valid = 1'b0;
      verdict("rand", l, e, fb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
